// File: rtl/logical_operand_sequencer_pkg.sv
// Shared constants for the operand sequencer stage.
// State encodings and default widths.
package logical_operand_sequencer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/logical_operand_sequencer_if.sv
// Operand stream, operator link and result
// handshake bundle for the sequencer stage.
interface logical_operand_sequencer_if
  import logical_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             op_valid;
  logic             x;
  logic             y;
  logic             res_x;
  logic             res_y;
  logic             res_valid;
  logic             res_ack;
  logic [CNT_W-1:0] txn_count;

  modport slave (
    input  flush, in_valid, in_data,
    input  x, y, res_ack,
    output in_ready, a, b, c, d,
    output op_valid, res_x, res_y,
    output res_valid, txn_count
  );

  modport master (
    output flush, in_valid, in_data,
    output x, y, res_ack,
    input  in_ready, a, b, c, d,
    input  op_valid, res_x, res_y,
    input  res_valid, txn_count
  );

endinterface

// File: rtl/logical_operand_sequencer.sv
// Serial-to-parallel operand loader feeding
// logical_operators, with registered results.
module logical_operand_sequencer
  import logical_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                        clk,
  input logic                        rst,
  logical_operand_sequencer_if.slave io
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [WIDTH-1:0] opnd_q [4];
  logic [WIDTH-1:0] opnd_d [4];
  logic             res_x_q, res_x_d;
  logic             res_y_q, res_y_d;
  logic             rvld_q, rvld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_load, is_eval, is_hold;
  logic             accept;

  assign is_load = (state_q == ST_LOAD);
  assign is_eval = (state_q == ST_EVAL);
  assign is_hold = (state_q == ST_HOLD);
  // flush beats a same-cycle operand
  assign accept  = is_load & io.in_valid
                 & ~io.flush;

  // next-state: load, evaluate, hold result
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opnd_d  = opnd_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    rvld_d  = rvld_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      is_load: begin
        if (io.flush) begin
          idx_d = 2'd0;
        end else if (accept) begin
          opnd_d[idx_q] = io.in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = ST_EVAL;
        end
      end
      is_eval: begin
        res_x_d = io.x;
        res_y_d = io.y;
        rvld_d  = 1'b1;
        state_d = ST_HOLD;
      end
      is_hold: begin
        if (io.res_ack) begin
          rvld_d  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: begin
        idx_d   = 2'd0;
        state_d = ST_LOAD;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= 2'd0;
      opnd_q  <= '{default: '0};
      res_x_q <= 1'b0;
      res_y_q <= 1'b0;
      rvld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opnd_q  <= opnd_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      rvld_q  <= rvld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.in_ready  = is_load;
  assign io.op_valid  = is_eval;
  assign io.a         = opnd_q[0];
  assign io.b         = opnd_q[1];
  assign io.c         = opnd_q[2];
  assign io.d         = opnd_q[3];
  assign io.res_x     = res_x_q;
  assign io.res_y     = res_y_q;
  assign io.res_valid = rvld_q;
  assign io.txn_count = cnt_q;

endmodule

// File: tb/tb_logical_operand_sequencer.sv
// Scoreboard bench for the operand sequencer.
// Random operand sets, flushes, gaps and acks.
module tb_logical_operand_sequencer;
  import logical_operand_sequencer_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [3:0][W-1:0] op;
    logic              x;
    logic              y;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic auto_ack;
  logic ack_rand;
  logic ack_man;

  int errs   = 0;
  int checks = 0;

  exp_t             sb [$];
  logic [W-1:0]     pend [$];
  logic [CW-1:0]    mcnt = '0;

  logical_operand_sequencer_if #(
    .WIDTH(W), .CNT_W(CW)
  ) bus ();

  logical_operand_sequencer #(
    .WIDTH(W), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  // stub of the downstream logical_operators block
  assign bus.x = ^{bus.a, bus.b, bus.c, bus.d};
  assign bus.y = &(bus.a ^ bus.d);
  assign bus.res_ack = auto_ack ? ack_rand
                                : ack_man;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ops();
    return {bus.a, bus.b, bus.c, bus.d};
  endfunction

  // reference: collect accepted operands, emit a set
  task automatic model_accept(input logic [W-1:0] v);
    exp_t e;
    pend.push_back(v);
    if (pend.size() == 4) begin
      for (int i = 0; i < 4; i++)
        e.op[3-i] = pend[i];
      e.x = ^{pend[0], pend[1], pend[2], pend[3]};
      e.y = &(pend[0] ^ pend[3]);
      sb.push_back(e);
      pend.delete();
    end
  endtask

  task automatic send(input logic [W-1:0] v,
                      input logic fl);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.flush    = fl;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    if (fl) pend.delete();
    else    model_accept(v);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic ack_one();
    int n = 0;
    while (!bus.res_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("ack_timeout", 1, 0);
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
  endtask

  // random acknowledge source
  initial begin
    ack_rand = 1'b0;
    forever begin
      @(posedge clk); #1;
      ack_rand = 1'($urandom_range(0, 1));
    end
  end

  // monitor: compare DUT outputs with scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      mcnt = '0;
    end else begin
      chk("txn_count", 32'(bus.txn_count),
          32'(mcnt));
      if (bus.op_valid) begin
        if (sb.size() == 0) begin
          chk("op_valid_unexpected", 1, 0);
        end else begin
          e = sb[0];
          chk("eval_ops", 32'(ops()), 32'(e.op));
        end
      end
      if (bus.res_valid && bus.res_ack) begin
        if (sb.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("res_xy", {30'd0, bus.res_x, bus.res_y},
              {30'd0, e.x, e.y});
          chk("hold_ops", 32'(ops()), 32'(e.op));
          mcnt = mcnt + 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] snap;
    logic [W-1:0] v;
    int n;
    rst          = 1'b1;
    auto_ack     = 1'b0;
    ack_man      = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;

    // reset held two cycles with in_valid high
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_ops", 32'(ops()), 0);
    chk("rst_flags",
        {27'd0, bus.op_valid, bus.res_x, bus.res_y,
         bus.res_valid, bus.in_ready},
        32'd1);
    chk("rst_cnt", 32'(bus.txn_count), 0);
    @(posedge clk); #1;

    // directed set with known results
    send(4'b1111, 1'b0);
    send(4'b1010, 1'b0);
    send(4'b1001, 1'b0);
    send(4'b1101, 1'b0);
    chk("dir_opv", 32'(bus.op_valid), 1);
    chk("dir_ops", 32'(ops()), 32'h FA9D);
    @(posedge clk); #1;
    chk("dir_res",
        {29'd0, bus.res_valid, bus.res_x, bus.res_y},
        32'b110);
    chk("dir_opv_off", 32'(bus.op_valid), 0);

    // ack held low: result and operands hold
    snap = ops();
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_state",
          {30'd0, bus.res_valid, bus.in_ready},
          32'b10);
      chk("hold_stable", 32'(ops()), 32'(snap));
    end
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
    chk("ack_cnt", 32'(bus.txn_count), 1);
    chk("ack_ready", 32'(bus.in_ready), 1);

    // flush after two operands; flushed operand dropped
    send(4'h3, 1'b0);
    send(4'h5, 1'b0);
    send(4'h7, 1'b1);
    chk("flush_ready", 32'(bus.in_ready), 1);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h4, 1'b0);
    send(4'h8, 1'b0);
    chk("flush_ops", 32'(ops()), 32'h1248);
    ack_one();
    chk("flush_cnt", 32'(bus.txn_count), 2);

    // reset while holding a result
    send(4'h6, 1'b0);
    send(4'hC, 1'b0);
    send(4'h0, 1'b0);
    send(4'hE, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_hold", 32'(bus.res_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("hold_rst",
        {29'd0, bus.res_valid, bus.op_valid,
         bus.in_ready},
        32'b001);
    chk("hold_rst_cnt", 32'(bus.txn_count), 0);

    // 256 random transactions; count wraps to zero
    auto_ack = 1'b1;
    for (int t = 0; t < 256; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++)
          send(W'($urandom), 1'b0);
        send(W'($urandom), 1'b1);
      end
      for (int k = 0; k < 4; k++) begin
        v = W'($urandom);
        send(v, 1'b0);
        idle($urandom_range(0, 2));
      end
    end
    n = 0;
    while ((sb.size() != 0 || !bus.in_ready)
           && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    chk("wrap_cnt", 32'(bus.txn_count), 0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
